// File: rtl/fir_result_tx.sv
// fir_result_tx: buffers 16-bit FIR results in a small FIFO and ships each one
// off-tile as a low/high byte pair under a four-phase req/ack handshake.
module fir_result_tx #(
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [15:0]             in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [7:0]              out_data,
   output logic                    out_req,
   output logic                    out_hi,
   input  logic                    out_ack,
   output logic                    busy,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] SEND_LO = 3'd1;
   localparam logic [2:0] REL_LO  = 3'd2;
   localparam logic [2:0] SEND_HI = 3'd3;
   localparam logic [2:0] REL_HI  = 3'd4;

   logic [15:0]            mem [DEPTH];
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;
   logic [LW-1:0]          count;
   logic                   full;
   logic                   empty;
   logic                   push;
   logic                   pop;
   logic [15:0]            head;
   logic [SYNC_STAGES-1:0] ack_sync;
   logic                   ack_s;
   logic [2:0]             state;
   logic [15:0]            word_q;

   assign full     = (count == LW'(DEPTH));
   assign empty    = (count == '0);
   assign in_ready = !full;
   assign push     = in_valid && in_ready;
   assign pop      = (state == IDLE) && !empty;
   assign head     = mem[rd_ptr];
   assign ack_s    = ack_sync[SYNC_STAGES-1];
   assign busy     = !empty || (state != IDLE);
   assign level    = count;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of block ordering.
   // Pointers are AW bits wide, so the DEPTH wrap comes for free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array is deliberately left out of reset; the pointers
   // and count define which entries are meaningful, and a resettable array
   // would block mapping onto RAM cells.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ack_sync <= '0;
      else
         ack_sync <= {ack_sync[SYNC_STAGES-2:0], out_ack};
   end

   // out_data/out_hi only load on the edge that raises out_req, which keeps
   // them stable for the whole request/release window seen by the host.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         word_q   <= '0;
         out_data <= '0;
         out_hi   <= 1'b0;
         out_req  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  word_q   <= head;
                  out_data <= head[7:0];
                  out_hi   <= 1'b0;
                  out_req  <= 1'b1;
                  state    <= SEND_LO;
               end
            end
            SEND_LO: begin
               if (ack_s) begin
                  out_req <= 1'b0;
                  state   <= REL_LO;
               end
            end
            REL_LO: begin
               if (!ack_s) begin
                  out_data <= word_q[15:8];
                  out_hi   <= 1'b1;
                  out_req  <= 1'b1;
                  state    <= SEND_HI;
               end
            end
            SEND_HI: begin
               if (ack_s) begin
                  out_req <= 1'b0;
                  state   <= REL_HI;
               end
            end
            REL_HI: begin
               if (!ack_s)
                  state <= IDLE;
            end
            default: begin
               out_req <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule
